// File: rtl/j_intseq_pkg.sv
// Shared constants and FSM encoding for the j_intseq interrupt sequencer.
// Holds the source count, the vector width and the 2-bit state encoding.
package j_intseq_pkg;
  localparam int NSRC = 6;
  localparam int IVW  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_SERV = 2'b10
  } state_t;
endpackage

// File: rtl/j_intseq_lat.sv
// j_intlat: one interrupt source -- rising-edge detect plus a pending latch.
// A new edge always wins over a same-cycle clear so no request is ever lost.
module j_intlat (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_src,
  input  logic i_clr,
  output logic o_pend,
  output logic o_pendNext
);
  logic r_prev;
  logic r_pend;
  logic w_edge;

  // prev resets to 0, so a source already high at reset release counts as an edge
  assign w_edge     = i_src & ~r_prev;
  assign o_pendNext = w_edge | (r_pend & ~i_clr);
  assign o_pend     = r_pend;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_prev <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      r_prev <= i_src;
      r_pend <= o_pendNext;
    end
  end
endmodule

// File: rtl/j_intseq.sv
// j_intseq: six-source interrupt sequencer with priority encoder and an
// IDLE/REQ/SERV handshake FSM; all outputs come straight from registers.
module j_intseq
  import j_intseq_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic [NSRC-1:0] i_irq_src,
  input  logic            i_ena_wr,
  input  logic [NSRC-1:0] i_ena_d,
  input  logic            i_clr_wr,
  input  logic [NSRC-1:0] i_clr_d,
  input  logic            i_ack,
  input  logic            i_iret,
  output logic            o_irq,
  output logic [IVW-1:0]  o_ivec,
  output logic [NSRC-1:0] o_pend,
  output logic [NSRC-1:0] o_ena,
  output logic            o_insrv
);
  state_t          r_state;
  logic            r_irq;
  logic [IVW-1:0]  r_ivec;
  logic [NSRC-1:0] r_ena;
  logic            r_insrv;

  logic [NSRC-1:0] w_pend;
  logic [NSRC-1:0] w_pendNext;
  logic [NSRC-1:0] w_clr;
  logic [NSRC-1:0] w_ackClr;
  logic [NSRC-1:0] w_enaNext;
  logic            w_ackTake;
  logic            w_keep;
  logic            w_candValid;
  logic [IVW-1:0]  w_cand;

  assign w_ackTake = (r_state == ST_REQ) && i_ack;
  assign w_ackClr  = w_ackTake ? (NSRC'(1) << r_ivec) : '0;
  assign w_clr     = ({NSRC{i_clr_wr}} & i_clr_d) | w_ackClr;
  assign w_enaNext = i_ena_wr ? i_ena_d : r_ena;

  // The offer is withdrawn on the values the source will hold next cycle,
  // so irq never stays up alongside a visibly disabled or cleared source.
  assign w_keep = w_enaNext[r_ivec] & w_pendNext[r_ivec];

  for (genvar g = 0; g < NSRC; g++) begin : g_lat
    j_intlat u_lat (
      .i_clk      (i_clk),
      .i_reset_n  (i_reset_n),
      .i_src      (i_irq_src[g]),
      .i_clr      (w_clr[g]),
      .o_pend     (w_pend[g]),
      .o_pendNext (w_pendNext[g])
    );
  end

  always_comb begin
    w_candValid = 1'b0;
    w_cand      = '0;
    for (int n = 0; n < NSRC; n++) begin
      if (w_pend[n] && r_ena[n]) begin
        w_candValid = 1'b1;
        w_cand      = IVW'(n);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_irq   <= 1'b0;
      r_ivec  <= '0;
      r_ena   <= '0;
      r_insrv <= 1'b0;
    end else begin
      if (i_ena_wr) r_ena <= i_ena_d;
      case (r_state)
        ST_IDLE: begin
          if (w_candValid) begin
            r_state <= ST_REQ;
            r_ivec  <= w_cand;
            r_irq   <= 1'b1;
          end
        end
        ST_REQ: begin
          // ivec is frozen here; ack beats a coincident withdrawal
          if (i_ack) begin
            r_state <= ST_SERV;
            r_irq   <= 1'b0;
            r_insrv <= 1'b1;
          end else if (!w_keep) begin
            r_state <= ST_IDLE;
            r_irq   <= 1'b0;
          end
        end
        ST_SERV: begin
          if (i_iret) begin
            r_state <= ST_IDLE;
            r_insrv <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_irq   <= 1'b0;
          r_insrv <= 1'b0;
        end
      endcase
    end
  end

  assign o_irq   = r_irq;
  assign o_ivec  = r_ivec;
  assign o_pend  = w_pend;
  assign o_ena   = r_ena;
  assign o_insrv = r_insrv;
endmodule

// File: tb/tb_j_intseq.sv
// Scoreboard bench for j_intseq: directed stimulus pushes hand-computed
// expectations tagged with a cycle; a negedge monitor pops and compares them.
module tb_j_intseq;
  logic       clk    = 1'b0;
  logic       rstN   = 1'b0;
  logic [5:0] irqSrc = '0;
  logic       enaWr  = 1'b0;
  logic [5:0] enaD   = '0;
  logic       clrWr  = 1'b0;
  logic [5:0] clrD   = '0;
  logic       ack    = 1'b0;
  logic       iret   = 1'b0;
  logic       irq;
  logic [2:0] ivec;
  logic [5:0] pend;
  logic [5:0] ena;
  logic       insrv;

  int cyc         = 0;
  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    int         atCyc;
    string      name;
    logic       irq;
    logic [2:0] ivec;
    logic [5:0] pend;
    logic [5:0] ena;
    logic       insrv;
  } expT;

  expT expQ[$];

  j_intseq dut (
    .i_clk     (clk),
    .i_reset_n (rstN),
    .i_irq_src (irqSrc),
    .i_ena_wr  (enaWr),
    .i_ena_d   (enaD),
    .i_clr_wr  (clrWr),
    .i_clr_d   (clrD),
    .i_ack     (ack),
    .i_iret    (iret),
    .o_irq     (irq),
    .o_ivec    (ivec),
    .o_pend    (pend),
    .o_ena     (ena),
    .o_insrv   (insrv)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic pushExp(input int offset, input string name, input logic eIrq,
                         input logic [2:0] eIvec, input logic [5:0] ePend,
                         input logic [5:0] eEna, input logic eInsrv);
    expT e;
    e.atCyc = cyc + offset;
    e.name  = name;
    e.irq   = eIrq;
    e.ivec  = eIvec;
    e.pend  = ePend;
    e.ena   = eEna;
    e.insrv = eInsrv;
    expQ.push_back(e);
  endtask

  // Inputs are held for exactly one cycle and sampled at the next rising edge.
  task automatic applyStimulus(input logic [5:0] src, input logic eW, input logic [5:0] eD,
                               input logic cW, input logic [5:0] cD,
                               input logic a, input logic r);
    irqSrc = src;
    enaWr  = eW;
    enaD   = eD;
    clrWr  = cW;
    clrD   = cD;
    ack    = a;
    iret   = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [5:0] src);
    applyStimulus(src, 1'b0, 6'h00, 1'b0, 6'h00, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input expT e);
    testsRun++;
    if ({irq, ivec, pend, ena, insrv} !== {e.irq, e.ivec, e.pend, e.ena, e.insrv}) begin
      testsFailed++;
      $display("[TB] FAIL %s @cyc %0d: got irq=%0b ivec=%0d pend=%h ena=%h insrv=%0b, want irq=%0b ivec=%0d pend=%h ena=%h insrv=%0b",
               e.name, cyc, irq, ivec, pend, ena, insrv, e.irq, e.ivec, e.pend, e.ena, e.insrv);
    end
  endtask

  always @(negedge clk) begin
    for (int i = expQ.size() - 1; i >= 0; i--) begin
      if (expQ[i].atCyc == cyc) begin
        checkOutput(expQ[i]);
        expQ.delete(i);
      end else if (expQ[i].atCyc < cyc) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL %s: expectation for cyc %0d never compared (now %0d)",
                 expQ[i].name, expQ[i].atCyc, cyc);
        expQ.delete(i);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstN = 1'b0;
    repeat (3) idle(6'h00);
    pushExp(0, "reset", 0, 0, 6'h00, 6'h00, 0);
    rstN = 1'b1;

    // Single source: latency and ack/iret handshake
    pushExp(1, "enaLoad", 0, 0, 6'h00, 6'h3F, 0);
    applyStimulus(6'h00, 1, 6'h3F, 0, 6'h00, 0, 0);
    pushExp(1, "pendSet", 0, 0, 6'h04, 6'h3F, 0);
    pushExp(2, "irqUp",   1, 2, 6'h04, 6'h3F, 0);
    idle(6'h04);
    idle(6'h00);
    pushExp(1, "reqHold", 1, 2, 6'h04, 6'h3F, 0);
    idle(6'h00);
    pushExp(1, "ackServ", 0, 2, 6'h00, 6'h3F, 1);
    applyStimulus(6'h00, 0, 6'h00, 0, 6'h00, 1, 0);
    pushExp(1, "iretIdle", 0, 2, 6'h00, 6'h3F, 0);
    applyStimulus(6'h00, 0, 6'h00, 0, 6'h00, 0, 1);
    pushExp(1, "ackIretIgnored", 0, 2, 6'h00, 6'h3F, 0);
    applyStimulus(6'h00, 0, 6'h00, 0, 6'h00, 1, 1);

    // Sources 1 and 4 together; source 5 arriving during REQ must not pre-empt
    pushExp(1, "dualPend", 0, 2, 6'h12, 6'h3F, 0);
    pushExp(2, "prioHigh", 1, 4, 6'h12, 6'h3F, 0);
    idle(6'h12);
    idle(6'h00);
    pushExp(1, "noPreempt", 1, 4, 6'h32, 6'h3F, 0);
    idle(6'h20);
    pushExp(1, "ack4", 0, 4, 6'h22, 6'h3F, 1);
    applyStimulus(6'h00, 0, 6'h00, 0, 6'h00, 1, 0);
    pushExp(1, "noNest", 0, 4, 6'h22, 6'h3F, 1);
    idle(6'h00);
    pushExp(1, "iret4",  0, 4, 6'h22, 6'h3F, 0);
    pushExp(2, "offer5", 1, 5, 6'h22, 6'h3F, 0);
    applyStimulus(6'h00, 0, 6'h00, 0, 6'h00, 0, 1);
    idle(6'h00);
    pushExp(1, "ack5", 0, 5, 6'h02, 6'h3F, 1);
    applyStimulus(6'h00, 0, 6'h00, 0, 6'h00, 1, 0);
    pushExp(1, "iret5",  0, 5, 6'h02, 6'h3F, 0);
    pushExp(2, "offer1", 1, 1, 6'h02, 6'h3F, 0);
    applyStimulus(6'h00, 0, 6'h00, 0, 6'h00, 0, 1);
    idle(6'h00);
    pushExp(1, "ack1", 0, 1, 6'h00, 6'h3F, 1);
    applyStimulus(6'h00, 0, 6'h00, 0, 6'h00, 1, 0);
    pushExp(1, "iret1", 0, 1, 6'h00, 6'h3F, 0);
    applyStimulus(6'h00, 0, 6'h00, 0, 6'h00, 0, 1);

    // Withdrawal by disable and by clear; ack beats a coincident withdrawal
    pushExp(2, "offer3", 1, 3, 6'h08, 6'h3F, 0);
    idle(6'h08);
    idle(6'h00);
    pushExp(1, "withdraw", 0, 3, 6'h08, 6'h00, 0);
    applyStimulus(6'h00, 1, 6'h00, 0, 6'h00, 0, 0);
    pushExp(1, "reEnable", 0, 3, 6'h08, 6'h3F, 0);
    pushExp(2, "reOffer3", 1, 3, 6'h08, 6'h3F, 0);
    applyStimulus(6'h00, 1, 6'h3F, 0, 6'h00, 0, 0);
    idle(6'h00);
    pushExp(1, "clrWithdraw", 0, 3, 6'h00, 6'h3F, 0);
    applyStimulus(6'h00, 0, 6'h00, 1, 6'h08, 0, 0);
    pushExp(2, "offer3b", 1, 3, 6'h08, 6'h3F, 0);
    idle(6'h08);
    idle(6'h00);
    pushExp(1, "ackWins", 0, 3, 6'h00, 6'h3F, 1);
    applyStimulus(6'h00, 0, 6'h00, 1, 6'h08, 1, 0);
    pushExp(1, "iret3", 0, 3, 6'h00, 6'h3F, 0);
    applyStimulus(6'h00, 0, 6'h00, 0, 6'h00, 0, 1);

    // Set beats clear; re-edge during ack; pending while in SERV
    pushExp(1, "setWins", 0, 3, 6'h20, 6'h3F, 0);
    pushExp(2, "offer5b", 1, 5, 6'h20, 6'h3F, 0);
    applyStimulus(6'h20, 0, 6'h00, 1, 6'h20, 0, 0);
    idle(6'h00);
    pushExp(1, "ackReSet", 0, 5, 6'h20, 6'h3F, 1);
    applyStimulus(6'h20, 0, 6'h00, 0, 6'h00, 1, 0);
    pushExp(1, "clrInServ", 0, 5, 6'h00, 6'h3F, 1);
    applyStimulus(6'h00, 0, 6'h00, 1, 6'h20, 0, 0);
    pushExp(1, "servPend", 0, 5, 6'h01, 6'h3F, 1);
    idle(6'h01);
    pushExp(1, "servHold", 0, 5, 6'h01, 6'h3F, 1);
    idle(6'h00);
    pushExp(1, "iretIdle0", 0, 5, 6'h01, 6'h3F, 0);
    pushExp(2, "offer0",    1, 0, 6'h01, 6'h3F, 0);
    applyStimulus(6'h00, 0, 6'h00, 0, 6'h00, 0, 1);
    idle(6'h00);

    // Reset during REQ aborts the offer; a later ack does nothing
    rstN = 1'b0;
    pushExp(1, "resetInReq", 0, 0, 6'h00, 6'h00, 0);
    idle(6'h00);
    rstN = 1'b1;
    pushExp(1, "ackAfterReset", 0, 0, 6'h00, 6'h00, 0);
    applyStimulus(6'h00, 0, 6'h00, 0, 6'h00, 1, 0);

    // Source held high through reset counts as an edge once, after release
    rstN = 1'b0;
    idle(6'h02);
    idle(6'h02);
    pushExp(0, "heldReset", 0, 0, 6'h00, 6'h00, 0);
    rstN = 1'b1;
    pushExp(1, "heldEdge", 0, 0, 6'h02, 6'h00, 0);
    idle(6'h02);
    pushExp(1, "noReEdge", 0, 0, 6'h02, 6'h00, 0);
    idle(6'h02);
    pushExp(1, "ena02",     0, 0, 6'h02, 6'h02, 0);
    pushExp(2, "offerHeld", 1, 1, 6'h02, 6'h02, 0);
    applyStimulus(6'h02, 1, 6'h02, 0, 6'h00, 0, 0);
    idle(6'h02);
    repeat (3) idle(6'h00);

    foreach (expQ[i]) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s: expectation for cyc %0d left unchecked", expQ[i].name, expQ[i].atCyc);
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule

// File: doc/j_intseq.md
J_INTSEQ -- requirements
Module: j_intseq

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-low reset; ports are listed clock and reset first.
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 reset_n  in  1  reset, synchronous and active-low.
REQ-004 irq_src  in  6  interrupt sources, level; bit n is source n; a rising edge requests.
REQ-005 ena_wr  in  1  one-cycle strobe; loads ena_d into the enable mask.
REQ-006 ena_d  in  6  enable mask data; 1 = source enabled.
REQ-007 clr_wr  in  1  one-cycle strobe; clears pending bits where clr_d is 1.
REQ-008 clr_d  in  6  pending-clear data, write-1-to-clear.
REQ-009 ack  in  1  core accepts the offered interrupt.
REQ-010 iret  in  1  core finished the service routine.
REQ-011 irq  out  1  interrupt request to the core.
REQ-012 ivec  out  3  index (0-5) of the offered or in-service source.
REQ-013 pend  out  6  pending latch status.
REQ-014 ena  out  6  enable mask readback.
REQ-015 insrv  out  1  high while in SERV state.

Function
REQ-016 Each source SHALL be sampled every cycle into prev[n]; an edge is irq_src[n]=1 and prev[n]=0.
REQ-017 An edge SHALL set pend[n] on the next rising clock edge, regardless of ena[n].
REQ-018 An edge and a clear (clr_wr with clr_d[n]=1) on the same cycle SHALL leave pend[n]=1: set wins.
REQ-019 The candidate SHALL be the highest index n with pend[n] and ena[n] both 1; otherwise there is no candidate.
REQ-020 FSM states SHALL be IDLE, REQ and SERV, 2-bit encoded.
REQ-021 IDLE with a candidate SHALL go to REQ next cycle, load ivec from the candidate, and assert irq.
REQ-022 In REQ, ivec SHALL stay frozen; a higher-priority arrival does not pre-empt the offer.
REQ-023 REQ with ack=1 SHALL go to SERV, drop irq, and clear pend[ivec] next cycle, unless a new edge on that source sets it again.
REQ-024 REQ with ena[ivec] or pend[ivec] found 0 and ack=0 SHALL withdraw to IDLE, with irq low next cycle.
REQ-025 If ack and withdrawal coincide, ack SHALL win.
REQ-026 SERV with iret=1 SHALL go to IDLE; a new offer is possible no earlier than the cycle after IDLE.
REQ-027 ack outside REQ and iret outside SERV SHALL be ignored.
REQ-028 No nesting: while in SERV, irq SHALL stay 0 whatever is pending.
REQ-029 Latency: source edge in cycle N -> pend at N+1 -> irq at N+2 when IDLE and enabled.
REQ-030 Outputs SHALL be registered; there is no combinational path from an input to irq or ivec.

Reset
REQ-031 When reset_n=0 at a clock edge, the block SHALL set state=IDLE, irq=0, ivec=0, pend=0, ena=0, insrv=0, prev=0.
REQ-032 A source held high when reset is released SHALL count as an edge on the first cycle.
REQ-033 Reset asserted in REQ or SERV SHALL abort with no ack or iret required.

Structure
REQ-034 A shared package SHALL hold the source count (6), the ivec width (3) and the FSM state encodings.
REQ-035 One sub-module, j_intlat, SHALL implement the per-source edge detect and pending latch, instantiated 6 times.
REQ-036 The priority encoder and FSM SHALL live in j_intseq.

Verification
REQ-037 ena=6'h3F; pulse irq_src[2] at cycle 10 -> pend=6'h04 at 11, irq=1 and ivec=2 at 12; ack at 14 -> irq=0, pend=0, insrv=1 at 15.
REQ-038 Edges on sources 1 and 4 on the same cycle, ena=6'h3F -> ivec=4 first; after ack and iret, ivec=1 is offered.
REQ-039 In REQ with ivec=3, write ena=6'h00 with ack low -> IDLE and irq=0 next cycle, pend[3] still 1.
REQ-040 Edge on source 5 plus clr_wr with clr_d=6'h20 on the same cycle -> pend[5]=1 (set wins).
REQ-041 In SERV, pulse source 0 -> irq stays 0; on iret, IDLE, then irq=1 and ivec=0 one cycle later.
REQ-042 Assert reset_n=0 for one cycle during REQ -> all outputs 0 next cycle; ack afterwards is ignored.
